// File: rtl/param_latch_bank_clocked.sv
// Bank of CHANNELS clocked WIDTH-bit "latches": transparent, gate-edge capture or hold,
// with per-channel sync preset, valid flags, change pulses and saturating change counters.
module param_latch_bank_clocked #(
  parameter int                WIDTH           = 4,
  parameter int                CHANNELS        = 4,
  parameter int                GATE_ACTIVE_LOW = 1,
  parameter logic [WIDTH-1:0]  PRESET_VAL      = {WIDTH{1'b1}},
  parameter int                CNT_W           = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [CHANNELS*WIDTH-1:0] D,
  input  logic [CHANNELS-1:0]       G,
  input  logic [CHANNELS-1:0]       SET,
  input  logic [1:0]                MODE,
  output logic [CHANNELS*WIDTH-1:0] Q,
  output logic [CHANNELS-1:0]       VALID,
  output logic [CHANNELS-1:0]       CHG,
  output logic [CHANNELS*CNT_W-1:0] CHG_CNT
);

  localparam logic [1:0] MODE_TRANSPARENT = 2'b00;
  localparam logic [1:0] MODE_EDGE        = 2'b01;

  logic                rst_hold;
  logic [CHANNELS-1:0] act;
  logic [CHANNELS-1:0] prev_act;
  logic [CHANNELS-1:0] valid_reg;
  logic [CHANNELS-1:0] valid_nxt;
  logic [CHANNELS-1:0] chg_reg;
  logic [WIDTH-1:0]    q_reg [CHANNELS];
  logic [WIDTH-1:0]    q_nxt [CHANNELS];
  logic [CNT_W-1:0]    cnt_reg [CHANNELS];

  always_comb begin
    act = (GATE_ACTIVE_LOW != 0) ? ~G : G;
    for (int i = 0; i < CHANNELS; i++) begin
      q_nxt[i]     = q_reg[i];
      valid_nxt[i] = valid_reg[i];
      if (SET[i]) begin
        q_nxt[i]     = PRESET_VAL;
        valid_nxt[i] = 1'b0;
      end else if (MODE == MODE_TRANSPARENT) begin
        if (act[i]) begin
          q_nxt[i]     = D[i*WIDTH +: WIDTH];
          valid_nxt[i] = 1'b1;
        end
      end else if (MODE == MODE_EDGE) begin
        if (prev_act[i] && !act[i]) begin
          q_nxt[i]     = D[i*WIDTH +: WIDTH];
          valid_nxt[i] = 1'b1;
        end
      end
    end
  end

  // rst_hold makes the first edge after reset release a no-op for every register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rst_hold  <= 1'b1;
      prev_act  <= '0;
      valid_reg <= '0;
      chg_reg   <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        q_reg[i]   <= PRESET_VAL;
        cnt_reg[i] <= '0;
      end
    end else if (rst_hold) begin
      rst_hold <= 1'b0;
    end else begin
      prev_act  <= act;
      valid_reg <= valid_nxt;
      for (int i = 0; i < CHANNELS; i++) begin
        q_reg[i]   <= q_nxt[i];
        chg_reg[i] <= (q_nxt[i] != q_reg[i]);
        if ((q_nxt[i] != q_reg[i]) && (cnt_reg[i] != {CNT_W{1'b1}}))
          cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_out
    assign Q[i*WIDTH +: WIDTH]       = q_reg[i];
    assign CHG_CNT[i*CNT_W +: CNT_W] = cnt_reg[i];
  end

  assign VALID = valid_reg;
  assign CHG   = chg_reg;

endmodule
